// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver with frame-synchronous BCD commit.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always lit).
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        bcd_valid,
    output logic        bcd_ready,
    input  logic        blank,
    output logic        frame_tick,
    output logic [6:0]  LED_out,
    output logic [3:0]  LED_anode
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [15:0]      disp_q, disp_d;
    logic [6:0]       led_q, led_d;
    logic [3:0]       anode_q, anode_d;

    logic       slot_end;
    logic       frame_end;
    logic       xfer;
    logic [3:0] cur_digit;
    logic [3:0] lz_dark;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
            default: decode = 7'b1111110;
        endcase
    endfunction

    // A digit is a leading zero when it and everything to its left is zero.
    assign lz_dark[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_lz
`ifdef LEADING_ZERO_BLANK_EN
            assign lz_dark[gi] = ~|disp_q[15:4*gi];
`else
            assign lz_dark[gi] = 1'b0;
`endif
        end
    endgenerate

    // Ready is forced low while reset is asserted so nothing transfers then.
    assign bcd_ready  = ~pend_full_q & ~rst;
    assign frame_tick = frame_end;
    assign LED_out    = led_q;
    assign LED_anode  = anode_q;

    always_comb begin
        slot_end    = (presc_q == PRESC_MAX);
        frame_end   = slot_end && (idx_q == 2'd3);
        xfer        = bcd_valid && bcd_ready;
        presc_d     = slot_end ? '0 : presc_q + 1'b1;
        idx_d       = slot_end ? idx_q + 2'd1 : idx_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        disp_d      = disp_q;
        // Commit and transfer are mutually exclusive: ready is low while full.
        if (frame_end && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end else if (xfer) begin
            pend_d      = bcd_in;
            pend_full_d = 1'b1;
        end
        cur_digit = disp_q[{idx_q, 2'b00} +: 4];
        anode_d   = ~(4'b0001 << idx_q);
        led_d     = decode(cur_digit);
        if (blank || lz_dark[idx_q]) begin
            anode_d = 4'b1111;
            led_d   = 7'b1111111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= 2'd0;
            pend_q      <= 16'h0000;
            pend_full_q <= 1'b0;
            disp_q      <= 16'h0000;
            led_q       <= 7'b1111111;
            anode_q     <= 4'b1111;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            disp_q      <= disp_d;
            led_q       <= led_d;
            anode_q     <= anode_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: time-based reference model checked every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_seg7_scan_driver;

    localparam int R = 4;
    localparam int FRAME = 4 * R;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic        bcd_valid;
    logic        bcd_ready;
    logic        blank;
    logic        frame_tick;
    logic [6:0]  LED_out;
    logic [3:0]  LED_anode;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    seg7_scan_driver #(.REFRESH_DIV(R)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
        .bcd_ready(bcd_ready), .blank(blank), .frame_tick(frame_tick),
        .LED_out(LED_out), .LED_anode(LED_anode)
    );

    always #5 clk = ~clk;

    // Reference state: elapsed cycles since reset, plus the pending/displayed words.
    int          m_t = 0;
    logic [15:0] m_pend = 16'h0;
    bit          m_full = 0;
    logic [15:0] m_disp = 16'h0;
    logic [6:0]  m_led = 7'h7f;
    logic [3:0]  m_anode = 4'hf;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;  1: return 7'b1001111;
            2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  9: return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    function automatic bit lz_rule_on();
`ifdef LEADING_ZERO_BLANK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_pend = 16'h0; m_full = 0; m_disp = 16'h0;
            m_led = 7'h7f; m_anode = 4'hf;
        end else begin
            int idx, dig;
            bit dark;
            idx  = (m_t / R) % 4;
            dig  = (int'(m_disp) >> (4 * idx)) % 16;
            dark = blank || (lz_rule_on() && idx > 0 && (int'(m_disp) >> (4 * idx)) == 0);
            m_anode = dark ? 4'hf : 4'(15 - (1 << idx));
            m_led   = dark ? 7'h7f : seg_of(dig);
            if ((m_t % FRAME) == FRAME - 1 && m_full) begin
                m_disp = m_pend; m_full = 0;
            end else if (bcd_valid && !m_full) begin
                m_pend = bcd_in; m_full = 1;
            end
            m_t++;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("anode", 16'(LED_anode), 16'(m_anode));
            check("segments", 16'(LED_out), 16'(m_led));
            check("ready", 16'(bcd_ready), 16'(!rst && !m_full));
            check("frame_tick", 16'(frame_tick), 16'((m_t % FRAME) == FRAME - 1));
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic send(input logic [15:0] v);
        int k = 0;
        bcd_in = v; bcd_valid = 1'b1;
        while (!bcd_ready && k < 200) begin step(1); k++; end
        if (k >= 200) check("send_timeout", 16'd1, 16'd0);
        step(1);
        bcd_valid = 1'b0;
    endtask

    task automatic wait_tick();
        int k = 0;
        @(negedge clk);
        while (!frame_tick && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) check("tick_timeout", 16'd1, 16'd0);
    endtask

    task automatic expect_digit(input string name, input logic [3:0] an, input logic [6:0] seg);
        int k = 0;
        @(negedge clk);
        while (LED_anode !== an && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) check({name, "_timeout"}, 16'd1, 16'd0);
        else check(name, 16'(LED_out), 16'(seg));
    endtask

    initial begin
        int p0, p1, nt;
        rst = 1'b1; bcd_in = 16'h0; bcd_valid = 1'b0; blank = 1'b0;
        @(posedge clk); #2;
        chk_en = 1;
        step(4);
        // 1. reset values and first frame
        @(negedge clk);
        check("rst_anode", 16'(LED_anode), 16'h000f);
        check("rst_seg", 16'(LED_out), 16'h007f);
        check("rst_ready", 16'(bcd_ready), 16'h0000);
        #3; rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 16'(bcd_ready), 16'h0001);
        expect_digit("first_d0", 4'b1110, 7'b0000001);
        expect_digit("first_d1", 4'b1101, 7'b0000001);
        wait_tick(); p0 = int'($time);
        wait_tick(); p1 = int'($time);
        check("tick_period", 16'((p1 - p0) / 10), 16'(FRAME));

        // 2. handshake and frame-aligned commit
        step(5);
        send(16'h1234);
        @(negedge clk);
        check("ready_drop", 16'(bcd_ready), 16'h0000);
        wait_tick();
        @(negedge clk);
        check("ready_back", 16'(bcd_ready), 16'h0001);
        expect_digit("d0_4", 4'b1110, 7'b1001100);
        expect_digit("d1_3", 4'b1101, 7'b0000110);
        expect_digit("d2_2", 4'b1011, 7'b0010010);
        expect_digit("d3_1", 4'b0111, 7'b1001111);

        // 3. back-pressure: 9999 held until ready returns
        send(16'h5678);
        send(16'h9999);
        expect_digit("bp_d0_8", 4'b1110, 7'b0000000);
        expect_digit("bp_d3_5", 4'b0111, 7'b0100100);
        wait_tick();
        expect_digit("bp_d0_9", 4'b1110, 7'b0000100);

        // 4. invalid nibbles and blank
        send(16'hA0F9);
        wait_tick();
        expect_digit("inv_d0", 4'b1110, 7'b0000100);
        expect_digit("inv_d1", 4'b1101, 7'b1111110);
        expect_digit("inv_d3", 4'b0111, 7'b1111110);
        blank = 1'b1;
        nt = 0;
        repeat (20) begin @(negedge clk); if (frame_tick) nt++; end
        check("blank_anode", 16'(LED_anode), 16'h000f);
        check("blank_ticks", 16'(nt > 0), 16'h0001);
        step(1); blank = 1'b0;

        // 5. reset with a value pending
        wait_tick(); step(2);
        send(16'h7777);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 16'(bcd_ready), 16'h0000);
        step(1); rst = 1'b0;
        @(negedge clk);
        check("mid_rst_anode", 16'(LED_anode), 16'h000f);
        wait_tick(); wait_tick();
        expect_digit("no_pending", 4'b1110, 7'b0000001);

        // 6. leading-zero values (model covers both build variants)
        send(16'h0405);
        wait_tick();
        expect_digit("lz_d0", 4'b1110, 7'b0100100);
        expect_digit("lz_d2", 4'b1011, 7'b1001100);
        step(FRAME);

        // randomized phase
        for (int i = 0; i < 120; i++) begin
            int sel = $urandom_range(0, 9);
            if (sel < 5) begin
                logic [15:0] v = 16'($urandom);
                if ($urandom_range(0, 3) != 0) v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                                   4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                if ($urandom_range(0, 3) == 0) v[15:8] = 8'h00;
                send(v);
            end else if (sel < 8) begin
                step($urandom_range(1, 20));
            end else if (sel == 8) begin
                blank = 1'b1; step($urandom_range(1, 10)); blank = 1'b0;
            end else begin
                rst = 1'b1; step($urandom_range(1, 2)); rst = 1'b0;
            end
        end
        step(2 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
